// File: rtl/cntr_8_pkg.sv
// Shared types and constants for the cntr_8 loadable up/down counter.
// State codes are fixed because o_state exposes them directly.
package cntr_8_pkg;

    localparam int STATE_W    = 3;
    localparam int CNTR_WIDTH = 8;

    // 3'b110 and 3'b111 are illegal and fall back to IDLE in the next-state logic.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101
    } state_e;

endpackage : cntr_8_pkg

// File: rtl/cntr_8_if.sv
// Signal bundle between cntr_8 and whatever drives it.
// There is no handshake: inputs are sampled on every rising clk edge, and outputs are registered.
interface cntr_8_if
    import cntr_8_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH
) ();

    logic               inc;
    logic               load;
    logic [WIDTH-1:0]   d_in;
    logic [WIDTH-1:0]   d_out;
    logic [STATE_W-1:0] o_state;

    modport master (
        output inc,
        output load,
        output d_in,
        input  d_out,
        input  o_state
    );

    modport slave (
        input  inc,
        input  load,
        input  d_in,
        output d_out,
        output o_state
    );

endinterface : cntr_8_if

// File: rtl/cntr_8_ns.sv
// Purely combinational next-state logic for the cntr_8 FSM.
// load has priority over inc in every state, including the illegal codes.
module cntr_8_ns
    import cntr_8_pkg::*;
(
    input  state_e state,
    input  logic   load,
    input  logic   inc,
    output state_e next_state
);

    always_comb begin
        next_state = IDLE;
        if (load) begin
            next_state = LOAD;
        end else begin
            unique case (state)
                IDLE, LOAD, INC2, DEC2: next_state = inc ? INC : DEC;
                INC:                    next_state = inc ? INC2 : DEC;
                DEC:                    next_state = inc ? INC : DEC2;
                default:                next_state = IDLE;
            endcase
        end
    end

endmodule : cntr_8_ns

// File: rtl/cntr_8.sv
// 8-bit loadable up/down counter with a Moore FSM; the new count is selected from next_state.
// When CNTR_SAT_EN is defined, the count saturates at all-ones and at zero instead of wrapping.
module cntr_8
    import cntr_8_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH
) (
    input  logic   clk,
    input  logic   reset_n,
    cntr_8_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    cntr_8_ns u_ns (
        .state      (state_q),
        .load       (bus.load),
        .inc        (bus.inc),
        .next_state (state_d)
    );

    always_comb begin
        cnt_d = '0;
        unique case (state_d)
            LOAD:      cnt_d = bus.d_in;
`ifdef CNTR_SAT_EN
            INC, INC2: cnt_d = (&cnt_q) ? cnt_q : cnt_q + ONE;
            DEC, DEC2: cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - ONE;
`else
            INC, INC2: cnt_d = cnt_q + ONE;
            DEC, DEC2: cnt_d = cnt_q - ONE;
`endif
            default:   cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.d_out   = cnt_q;
    assign bus.o_state = state_q;

endmodule : cntr_8

// File: tb/tb_cntr_8.sv
// Directed testbench for cntr_8: reset, counting, load, wrap/saturate, load priority and mid-count reset.
// Expected values are hand-computed; the saturating variant is selected by CNTR_SAT_EN.
module tb_cntr_8;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    cntr_8_if #(.WIDTH(8)) bus_if ();

    cntr_8 #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] exp_st, input logic [7:0] exp_d);
        checks++;
        if (bus_if.o_state !== exp_st || bus_if.d_out !== exp_d) begin
            errors++;
            $display("FAIL %s: got state=%b d_out=%h, expected state=%b d_out=%h",
                     name, bus_if.o_state, bus_if.d_out, exp_st, exp_d);
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b1;
        bus_if.load = 1'b0;
        bus_if.inc  = 1'b1;
        bus_if.d_in = 8'h0F;
        #1 reset_n = 1'b0;
        #1 check("reset_async", 3'b000, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_hold", 3'b000, 8'h00);
        end
    endtask

    task automatic test_count_up();
        logic [2:0] exp_st [4] = '{3'b010, 3'b011, 3'b010, 3'b011};
        logic [7:0] exp_d  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        #3 reset_n = 1'b1;
        bus_if.load = 1'b0;
        bus_if.inc  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("count_up", exp_st[i], exp_d[i]);
        end
    endtask

    task automatic test_load();
        logic [2:0] exp_st [3] = '{3'b010, 3'b011, 3'b010};
        logic [7:0] exp_d  [3] = '{8'h10, 8'h11, 8'h12};
        bus_if.load = 1'b1;
        bus_if.d_in = 8'h0F;
        for (int i = 0; i < 2; i++) begin
            step();
            check("load", 3'b001, 8'h0F);
        end
        bus_if.load = 1'b0;
        bus_if.inc  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("after_load_up", exp_st[i], exp_d[i]);
        end
    endtask

    task automatic test_count_down();
        logic [2:0] exp_st [4] = '{3'b100, 3'b101, 3'b100, 3'b101};
        logic [7:0] exp_d  [4] = '{8'h11, 8'h10, 8'h0F, 8'h0E};
        bus_if.inc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("count_down", exp_st[i], exp_d[i]);
        end
    endtask

    task automatic test_wrap();
`ifdef CNTR_SAT_EN
        logic [7:0] up0 = 8'hFF, up1 = 8'hFF, dn0 = 8'h00, dn1 = 8'h00;
`else
        logic [7:0] up0 = 8'h00, up1 = 8'h01, dn0 = 8'hFF, dn1 = 8'hFE;
`endif
        bus_if.load = 1'b1;
        bus_if.d_in = 8'hFF;
        step();
        check("wrap_load_ff", 3'b001, 8'hFF);
        bus_if.load = 1'b0;
        bus_if.inc  = 1'b1;
        step();
        check("wrap_up", 3'b010, up0);
        step();
        check("wrap_up2", 3'b011, up1);
        bus_if.load = 1'b1;
        bus_if.d_in = 8'h00;
        step();
        check("wrap_load_00", 3'b001, 8'h00);
        bus_if.load = 1'b0;
        bus_if.inc  = 1'b0;
        step();
        check("wrap_down", 3'b100, dn0);
        step();
        check("wrap_down2", 3'b101, dn1);
    endtask

    task automatic test_load_priority();
        bus_if.load = 1'b1;
        bus_if.inc  = 1'b1;
        bus_if.d_in = 8'h5A;
        step();
        check("prio_load_inc1", 3'b001, 8'h5A);
        bus_if.inc  = 1'b0;
        bus_if.d_in = 8'hA5;
        step();
        check("prio_load_inc0", 3'b001, 8'hA5);
        bus_if.load = 1'b0;
        bus_if.inc  = 1'b1;
        step();
        check("prio_then_up", 3'b010, 8'hA6);
    endtask

    task automatic test_reset_mid();
        bus_if.load = 1'b0;
        bus_if.inc  = 1'b1;
        step();
        check("mid_pre", 3'b011, 8'hA7);
        #2;
        bus_if.load = 1'b1;
        bus_if.d_in = 8'h33;
        reset_n     = 1'b0;
        #1 check("mid_async", 3'b000, 8'h00);
        step();
        check("mid_hold", 3'b000, 8'h00);
        #2 reset_n = 1'b1;
        step();
        check("mid_release_load", 3'b001, 8'h33);
        bus_if.load = 1'b0;
        bus_if.inc  = 1'b0;
        step();
        check("mid_then_down", 3'b100, 8'h32);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count_up();
        test_load();
        test_count_down();
        test_wrap();
        test_load_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cntr_8
